// File: rtl/data_memory_backend_if.sv
// Cache-to-memory handshake bundle: level-held request, one-cycle ready strobe.
interface data_memory_backend_if;
  logic        memory_request;
  logic        memory_write;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        memory_ready;
  logic [63:0] memory_data;
  logic        busy;

  modport master (
    output memory_request, memory_write, address, write_data,
    input  memory_ready, memory_data, busy
  );

  modport slave (
    input  memory_request, memory_write, address, write_data,
    output memory_ready, memory_data, busy
  );
endinterface

// File: rtl/data_memory_backend.sv
// Word-per-line backing memory for the DataCache with fixed response latency.
// One transaction at a time: IDLE -> WAIT* -> RESP -> GAP -> IDLE.
module data_memory_backend #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_backend_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          capture;
  logic [IW-1:0] cap_idx;
  logic          cap_write;
  logic [63:0]   cap_data;
  logic [IW-1:0] resp_idx;
  logic          resp_write;
  logic [63:0]   resp_wdata;
  logic          ready_q;
  logic [63:0]   data_q;
  logic [63:0]   mem [DEPTH_WORDS];
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{bus.address[63:IW+3], bus.address[2:0]};

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.memory_request) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (!bus.memory_request)  state_next = IDLE;
        else if (count == '0)     state_next = RESP;
        else                      count_next = count - CW'(1);
      end
      RESP:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 the response is formed on the same edge as the capture,
  // so the live request fields bypass the capture registers.
  always_comb begin
    resp_idx   = capture ? bus.address[IW+2:3] : cap_idx;
    resp_write = capture ? bus.memory_write    : cap_write;
    resp_wdata = capture ? bus.write_data      : cap_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_data  <= '0;
      ready_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ready_q <= (state_next == RESP);
      if (capture) begin
        cap_idx   <= bus.address[IW+2:3];
        cap_write <= bus.memory_write;
        cap_data  <= bus.write_data;
      end
      if (state_next == RESP)
        data_q <= resp_write ? resp_wdata : mem[resp_idx];
    end
  end

  // Array is deliberately not reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && cap_write)
      mem[cap_idx] <= cap_data;
  end

  assign bus.memory_ready = ready_q;
  assign bus.memory_data  = data_q;
  assign bus.busy         = (state != IDLE);
endmodule
